// File: rtl/io_uart_tx_port.sv
// Memory-mapped UART 8N1 transmitter: stores on the I/O slot fill a small byte FIFO,
// which is drained onto the serial line; loads return a live status word.
module io_uart_tx_port #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_wEn,
  input  logic [31:0] io_data_in,
  output logic [31:0] io_data_out,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         r_state;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overrun;
  logic [BW-1:0]  r_baud;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           r_busy;

  logic w_full, w_empty, w_push, w_drop, w_clr, w_wrap, w_pop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = io_wEn & ~io_data_in[31] & ~w_full;
  assign w_drop  = io_wEn & ~io_data_in[31] & w_full;
  assign w_clr   = io_wEn & io_data_in[31];
  assign w_wrap  = (r_baud == BAUD_LAST);
  // Pops look only at the registered count, so a byte is never popped on its write edge.
  assign w_pop   = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_wrap));

  assign tx          = r_tx;
  assign busy        = r_busy;
  assign io_data_out = {23'd0, 5'(r_count), r_overrun, w_full, w_empty, r_busy};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_clr)       r_overrun <= 1'b0;
      else if (w_drop) r_overrun <= 1'b1;

      if (r_state == IDLE) r_baud <= '0;
      else                 r_baud <= w_wrap ? '0 : r_baud + BW'(1);

      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_wrap) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
        end
        DATA: begin
          if (w_wrap) begin
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end
        end
        STOP: begin
          // Chain straight into the next start bit when more bytes are queued.
          if (w_wrap) begin
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_uart_tx_port.md
Name: io_uart_tx_port

Overview:
- Memory-mapped I/O responder that sits on one RAM I/O slot (write-enable strobe plus 32-bit write data in, 32-bit status word out).
- Processor stores to the slot's address push bytes into a small transmit FIFO.
- Bytes are serialized onto a UART 8N1 line.
- Processor loads from the slot return a live status word (busy, empty, full, overrun, count).

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 4, transmit FIFO entries; power of 2, 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- io_wEn  input  1  one-cycle write strobe from the RAM I/O slot.
- io_data_in  input  32  write data from the RAM I/O slot.
- io_data_out  output  32  status word returned to the RAM I/O slot.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is on the line.

Behaviour:
- Clock/reset (already decided): one clock, clk; reset is synchronous and active-high.
- Reset values: tx=1, busy=0, FIFO empty (count=0), overrun=0, FSM=IDLE, baud and bit counters 0, io_data_out=0x00000002.
- Reset asserted mid-frame: tx=1 after the next edge; FIFO flushed; partial frame abandoned.
- Write decode, on any edge with io_wEn=1:
  - io_data_in[31]=1: control write. Clears overrun; nothing enqueued; bits [30:0] ignored.
  - io_data_in[31]=0 and FIFO not full: enqueue io_data_in[7:0]; bits [30:8] ignored.
  - io_data_in[31]=0 and FIFO full: byte dropped; overrun set (sticky). This holds even if a pop occurs on the same edge.
- Status word is combinational from registered state; a write is visible in it on the cycle after the write edge.
  - [0] busy
  - [1] empty
  - [2] full
  - [3] overrun
  - [8:4] count (zero-extended)
  - [31:9] zero
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. On an edge with count>0, pop the FIFO head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], held CLKS_PER_BIT cycles per bit; shift right after each bit. After bit index 7, go to STOP. Order is LSB first.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end: if count>0, pop and go directly to START (no idle gap); else go to IDLE.
- Pop decisions use the registered count only. A byte written on edge N is popped no earlier than edge N+1, so an empty FIFO has no write/pop hazard.
- Simultaneous push and pop on one edge: count unchanged; both take effect.
- Latency, FIFO empty and IDLE:
  - Write on edge N → tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - busy=1 from edge N+1 until the edge that returns the FSM to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Bit transitions occur only on the wrap edge.
- FIFO read/write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- full = (count==FIFO_DEPTH); empty = (count==0).

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset check: hold reset 3 cycles → tx=1, busy=0, io_data_out=0x00000002.
- Single byte: write 0x000000A5 at edge N.
  - tx=0 during cycles N+1..N+4.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Stop bit = 1 for 4 cycles.
  - busy drops at edge N+41; status returns to 0x00000002.
- Back-to-back: write 0x11, 0x22, 0x33 on consecutive edges.
  - Status shows count=2 while the first frame is sent.
  - Frames are contiguous, with no extra idle cycles between the stop bit and the next start bit.
  - Total busy time = 120 cycles.
- Overrun: write 6 bytes on consecutive edges.
  - First is popped; 4 are queued, so full=1 (status bit 2) and count=4.
  - Sixth write is dropped; overrun=1 (bit 3).
  - Control write 0x80000000 clears overrun without changing count.
- Reset mid-frame: write 0x00 and 0xFF, then assert reset during DATA bit 3 → tx=1, count=0, busy=0 on the next edge; no further low bits appear on tx.
- Upper bits ignored: write 0x7FFFFF3C → transmitted byte is 0x3C; overrun unchanged.
